mc_core_param: RTL and testbench

Parametrised multi-cycle execution core: successor to the fixed 16-bit multi-cycle datapath, now with an integrated control FSM, data width `WIDTH`, address width `AW`, and a single memory port with variable-latency ready handshake. It also adds illegal-instruction trapping, a retired-instruction counter and a registered WWD output strobe. It sits between the unified memory model and the testbench/IO.

---
 rtl/mc_core_param.sv | 256 +++++++++++++++++++++++++
 tb/tb_mc_core_param.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_core_param.sv
// Parametrised multi-cycle execution core with integrated control FSM,
// single variable-latency memory port, illegal-op trap and retire counter.
module mc_core_param #(
    parameter int             WIDTH    = 16,
    parameter int             AW       = 16,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             is_halted,
    output logic             illegal,
    output logic [31:0]      num_inst,
    output logic [AW-1:0]    pc
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_BGZ = 4'd2;
    localparam logic [3:0] OP_BLZ = 4'd3;
    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_R   = 4'd15;

    localparam logic [5:0] F_JPR = 6'd25;
    localparam logic [5:0] F_JRL = 6'd26;
    localparam logic [5:0] F_WWD = 6'd28;
    localparam logic [5:0] F_HLT = 6'd29;

    logic [2:0]       r_state;
    logic [AW-1:0]    r_pc;
    logic [15:0]      r_ir;
    logic [WIDTH-1:0] r_gpr [4];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_aluout;
    logic [WIDTH-1:0] r_mdr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_illegal;
    logic [31:0]      r_num_inst;

    logic [3:0]       w_op;
    logic [1:0]       w_rs;
    logic [1:0]       w_rt;
    logic [1:0]       w_rd;
    logic [5:0]       w_func;
    logic [7:0]       w_imm;
    logic [11:0]      w_target;
    logic [WIDTH-1:0] w_sext;
    logic [WIDTH-1:0] w_zext;
    logic [AW-1:0]    w_off;
    logic [AW-1:0]    w_pc_inc;
    logic [AW-1:0]    w_br_target;
    logic [AW-1:0]    w_jmp_target;
    logic [WIDTH-1:0] w_link;
    logic             w_illegal;
    logic             w_taken;
    logic [WIDTH-1:0] w_alu;
    logic [1:0]       w_dest;
    logic [WIDTH-1:0] w_wb_val;

    assign w_op     = r_ir[15:12];
    assign w_rs     = r_ir[11:10];
    assign w_rt     = r_ir[9:8];
    assign w_rd     = r_ir[7:6];
    assign w_func   = r_ir[5:0];
    assign w_imm    = r_ir[7:0];
    assign w_target = r_ir[11:0];

    assign w_sext       = {{(WIDTH-8){w_imm[7]}}, w_imm};
    assign w_zext       = {{(WIDTH-8){1'b0}}, w_imm};
    assign w_off        = {{(AW-8){w_imm[7]}}, w_imm};
    assign w_pc_inc     = r_pc + AW'(1);
    assign w_br_target  = w_pc_inc + w_off;
    // Jump keeps the upper PC bits of PC+1 and replaces the low 12.
    assign w_jmp_target = (w_pc_inc & ~AW'(12'hFFF)) | AW'(w_target);
    assign w_link       = WIDTH'(w_pc_inc);

    always_comb begin
        w_illegal = 1'b0;
        if (w_op >= 4'd11 && w_op <= 4'd14) begin
            w_illegal = 1'b1;
        end else if (w_op == OP_R) begin
            if (w_func > 6'd7 && w_func != F_JPR && w_func != F_JRL &&
                w_func != F_WWD && w_func != F_HLT) begin
                w_illegal = 1'b1;
            end
        end
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_op)
            OP_BNE:  w_taken = (r_a != r_b);
            OP_BEQ:  w_taken = (r_a == r_b);
            OP_BGZ:  w_taken = !r_a[WIDTH-1] && (|r_a);
            OP_BLZ:  w_taken = r_a[WIDTH-1];
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADI:         w_alu = r_a + w_sext;
            OP_ORI:         w_alu = r_a | w_zext;
            OP_LHI:         w_alu = w_sext << 8;
            OP_LWD, OP_SWD: w_alu = r_a + w_sext;
            OP_R: begin
                case (w_func)
                    6'd0:    w_alu = r_a + r_b;
                    6'd1:    w_alu = r_a - r_b;
                    6'd2:    w_alu = r_a & r_b;
                    6'd3:    w_alu = r_a | r_b;
                    6'd4:    w_alu = ~r_a;
                    6'd5:    w_alu = ~r_a + WIDTH'(1);
                    6'd6:    w_alu = r_a << 1;
                    6'd7:    w_alu = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
                    default: w_alu = '0;
                endcase
            end
            default: w_alu = '0;
        endcase
    end

    assign w_dest   = (w_op == OP_R) ? w_rd : w_rt;
    assign w_wb_val = (w_op == OP_LWD) ? r_mdr : r_aluout;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_aluout    <= '0;
            r_mdr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_illegal   <= 1'b0;
            r_num_inst  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_gpr[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= mem_rdata[15:0];
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a <= r_gpr[w_rs];
                    r_b <= r_gpr[w_rt];
                    if (w_illegal) begin
                        r_illegal <= 1'b1;
                        r_state   <= S_HALT;
                    end else if (w_op == OP_R && w_func == F_HLT) begin
                        r_state <= S_HALT;
                    end else if (w_op == OP_JMP || w_op == OP_JAL) begin
                        r_pc       <= w_jmp_target;
                        r_num_inst <= r_num_inst + 32'd1;
                        r_state    <= S_FETCH;
                        if (w_op == OP_JAL) r_gpr[2] <= w_link;
                    end else if (w_op == OP_R && (w_func == F_JPR || w_func == F_JRL)) begin
                        r_pc       <= AW'(r_gpr[w_rs]);
                        r_num_inst <= r_num_inst + 32'd1;
                        r_state    <= S_FETCH;
                        if (w_func == F_JRL) r_gpr[2] <= w_link;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_op <= OP_BLZ) begin
                        r_pc       <= w_taken ? w_br_target : w_pc_inc;
                        r_num_inst <= r_num_inst + 32'd1;
                        r_state    <= S_FETCH;
                    end else if (w_op == OP_R && w_func == F_WWD) begin
                        r_out_data  <= r_a;
                        r_out_valid <= 1'b1;
                        r_pc        <= w_pc_inc;
                        r_num_inst  <= r_num_inst + 32'd1;
                        r_state     <= S_FETCH;
                    end else if (w_op == OP_LWD || w_op == OP_SWD) begin
                        r_aluout <= w_alu;
                        r_state  <= S_MEM;
                    end else begin
                        r_aluout <= w_alu;
                        r_state  <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_op == OP_SWD) begin
                            r_pc       <= w_pc_inc;
                            r_num_inst <= r_num_inst + 32'd1;
                            r_state    <= S_FETCH;
                        end else begin
                            r_mdr   <= mem_rdata;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    r_gpr[w_dest] <= w_wb_val;
                    r_pc          <= w_pc_inc;
                    r_num_inst    <= r_num_inst + 32'd1;
                    r_state       <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    // Memory port is a pure decode of registered state, so it holds steady across waits.
    assign mem_req   = (r_state == S_FETCH) || (r_state == S_MEM);
    assign mem_we    = (r_state == S_MEM) && (w_op == OP_SWD);
    assign mem_addr  = (r_state == S_FETCH) ? r_pc : AW'(r_aluout);
    assign mem_wdata = r_b;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign is_halted = (r_state == S_HALT);
    assign illegal   = r_illegal;
    assign num_inst  = r_num_inst;
    assign pc        = r_pc;

endmodule

// File: tb/tb_mc_core_param.sv
// Directed bench for mc_core_param: programs run from a ROM/RAM memory model with configurable wait states.
module tb_mc_core_param;

    localparam int W  = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;
    logic          mem_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          is_halted;
    logic          illegal;
    logic [31:0]   num_inst;
    logic [AW-1:0] pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_core_param #(.WIDTH(W), .AW(AW), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .out_valid(out_valid), .out_data(out_data), .is_halted(is_halted),
        .illegal(illegal), .num_inst(num_inst), .pc(pc)
    );

    // Program/constant ROM written by the stimulus, RAM overlay written by the core.
    logic [W-1:0]  rom   [0:255];
    logic [W-1:0]  ram   [0:255];
    logic          ram_v [0:255];
    int unsigned   wait_cfg = 0;
    int unsigned   wcnt = 0;
    int            wr_cnt, rd_cnt, wwd_cnt, unstable;
    logic [AW-1:0] last_waddr;
    logic [W-1:0]  last_wdata;
    logic [AW-1:0] rd_log  [0:63];
    logic [W-1:0]  wwd_log [0:15];
    logic          prev_wait;
    logic          prev_we;
    logic [AW-1:0] prev_addr;
    logic [W-1:0]  prev_wdata;

    assign mem_ready = (wcnt >= wait_cfg);
    assign mem_rdata = ram_v[mem_addr[7:0]] ? ram[mem_addr[7:0]] : rom[mem_addr[7:0]];

    always @(posedge clk) begin
        if (!reset_n) begin
            wcnt      <= 0;
            wr_cnt    <= 0;
            rd_cnt    <= 0;
            wwd_cnt   <= 0;
            unstable  <= 0;
            prev_wait <= 1'b0;
            for (int i = 0; i < 256; i++) ram_v[i] <= 1'b0;
        end else begin
            if (mem_req && !mem_ready) wcnt <= wcnt + 1;
            else                       wcnt <= 0;
            prev_wait  <= mem_req && !mem_ready;
            prev_addr  <= mem_addr;
            prev_we    <= mem_we;
            prev_wdata <= mem_wdata;
            if (prev_wait && mem_req &&
                (mem_addr !== prev_addr || mem_we !== prev_we || (mem_we && mem_wdata !== prev_wdata)))
                unstable <= unstable + 1;
            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    ram[mem_addr[7:0]]   <= mem_wdata;
                    ram_v[mem_addr[7:0]] <= 1'b1;
                    wr_cnt     <= wr_cnt + 1;
                    last_waddr <= mem_addr;
                    last_wdata <= mem_wdata;
                end else begin
                    if (rd_cnt < 64) rd_log[rd_cnt] <= mem_addr;
                    rd_cnt <= rd_cnt + 1;
                end
            end
            if (out_valid) begin
                if (wwd_cnt < 16) wwd_log[wwd_cnt] <= out_data;
                wwd_cnt <= wwd_cnt + 1;
            end
        end
    end

    function automatic logic [W-1:0] ei(input logic [3:0] op, input logic [1:0] rs,
                                        input logic [1:0] rt, input logic [7:0] imm);
        return {16'h0000, op, rs, rt, imm};
    endfunction

    function automatic logic [W-1:0] er(input logic [1:0] rs, input logic [1:0] rt,
                                        input logic [1:0] rd, input logic [5:0] func);
        return {16'h0000, 4'hF, rs, rt, rd, func};
    endfunction

    function automatic logic [W-1:0] ej(input logic [3:0] op, input logic [11:0] target);
        return {16'h0000, op, target};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_to_halt(output int cycles);
        cycles = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk);
            #1;
            if (is_halted === 1'b1) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clear_rom();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", pc); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (is_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", is_halted); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
        checks++; if (num_inst !== 32'd0) begin errors++; $display("FAIL reset_num_inst got %0d want 0", num_inst); end
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_fetch_req got req=%b we=%b want 1/0", mem_req, mem_we); end
    endtask

    task automatic test_basic(input int unsigned waits, input int exp_cycles);
        int cyc;
        clear_rom();
        rom[0] = ei(4'h4, 2'd0, 2'd1, 8'h05);
        rom[1] = ei(4'h4, 2'd1, 2'd2, 8'hFF);
        rom[2] = er(2'd1, 2'd2, 2'd3, 6'd0);
        rom[3] = er(2'd3, 2'd0, 2'd0, 6'd28);
        rom[4] = er(2'd0, 2'd0, 2'd0, 6'd29);
        wait_cfg = waits;
        do_reset();
        run_to_halt(cyc);
        checks++; if (cyc != exp_cycles) begin errors++; $display("FAIL basic_cycles w%0d got %0d want %0d", waits, cyc, exp_cycles); end
        checks++; if (wwd_cnt != 1) begin errors++; $display("FAIL basic_wwd_pulses w%0d got %0d want 1", waits, wwd_cnt); end
        checks++; if (wwd_log[0] !== 32'd9 || out_data !== 32'd9) begin errors++; $display("FAIL basic_out_data w%0d got %h/%h want 9", waits, wwd_log[0], out_data); end
        checks++; if (num_inst !== 32'd4) begin errors++; $display("FAIL basic_num_inst w%0d got %0d want 4", waits, num_inst); end
        checks++; if (illegal !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_flags w%0d got ill=%b ov=%b want 0/0", waits, illegal, out_valid); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL basic_addr_stable w%0d got %0d changes want 0", waits, unstable); end
        checks++; if (pc !== 16'h0004) begin errors++; $display("FAIL basic_final_pc w%0d got %h want 0004", waits, pc); end
    endtask

    task automatic test_load_store();
        int cyc;
        clear_rom();
        rom[8'h40] = 32'hDEADBEEF;
        rom[0] = ei(4'h7, 2'd0, 2'd1, 8'h40);
        rom[1] = ei(4'h8, 2'd0, 2'd1, 8'h10);
        rom[2] = ei(4'h7, 2'd0, 2'd2, 8'h10);
        rom[3] = er(2'd2, 2'd0, 2'd0, 6'd28);
        rom[4] = er(2'd0, 2'd0, 2'd0, 6'd29);
        wait_cfg = 0;
        do_reset();
        run_to_halt(cyc);
        checks++; if (cyc != 19) begin errors++; $display("FAIL ls_cycles got %0d want 19", cyc); end
        checks++; if (wr_cnt != 1) begin errors++; $display("FAIL ls_write_count got %0d want 1", wr_cnt); end
        checks++; if (last_waddr !== 16'h0010) begin errors++; $display("FAIL ls_waddr got %h want 0010", last_waddr); end
        checks++; if (last_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ls_wdata got %h want deadbeef", last_wdata); end
        checks++; if (wwd_log[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL ls_reload got %h want deadbeef", wwd_log[0]); end
        checks++; if (num_inst !== 32'd4) begin errors++; $display("FAIL ls_num_inst got %0d want 4", num_inst); end
        checks++; if (rd_cnt != 7) begin errors++; $display("FAIL ls_read_count got %0d want 7", rd_cnt); end
    endtask

    task automatic test_branch_jump();
        int cyc;
        logic [AW-1:0] exp_pc [0:8];
        exp_pc = '{16'h0, 16'h1, 16'h3, 16'h5, 16'h6, 16'h20, 16'h21, 16'h7, 16'h8};
        clear_rom();
        rom[0]     = ei(4'h4, 2'd0, 2'd1, 8'hFF);
        rom[1]     = ei(4'h3, 2'd1, 2'd0, 8'h01);
        rom[2]     = ei(4'h4, 2'd0, 2'd3, 8'h77);
        rom[3]     = ei(4'h0, 2'd1, 2'd0, 8'h01);
        rom[4]     = ei(4'h4, 2'd0, 2'd3, 8'h55);
        rom[5]     = ei(4'h0, 2'd0, 2'd0, 8'h10);
        rom[6]     = ej(4'hA, 12'h020);
        rom[7]     = er(2'd3, 2'd0, 2'd0, 6'd28);
        rom[8]     = er(2'd0, 2'd0, 2'd0, 6'd29);
        rom[8'h20] = er(2'd2, 2'd0, 2'd0, 6'd28);
        rom[8'h21] = er(2'd2, 2'd0, 2'd0, 6'd25);
        wait_cfg = 0;
        do_reset();
        run_to_halt(cyc);
        checks++; if (cyc != 25) begin errors++; $display("FAIL bj_cycles got %0d want 25", cyc); end
        checks++; if (rd_cnt != 9) begin errors++; $display("FAIL bj_fetch_count got %0d want 9", rd_cnt); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (rd_log[i] !== exp_pc[i]) begin errors++; $display("FAIL bj_pc_seq[%0d] got %h want %h", i, rd_log[i], exp_pc[i]); end
        end
        checks++; if (wwd_cnt != 2) begin errors++; $display("FAIL bj_wwd_count got %0d want 2", wwd_cnt); end
        checks++; if (wwd_log[0] !== 32'd7) begin errors++; $display("FAIL bj_link got %h want 7", wwd_log[0]); end
        checks++; if (wwd_log[1] !== 32'd0) begin errors++; $display("FAIL bj_skipped_r3 got %h want 0", wwd_log[1]); end
        checks++; if (num_inst !== 32'd8) begin errors++; $display("FAIL bj_num_inst got %0d want 8", num_inst); end
        checks++; if (pc !== 16'h0008) begin errors++; $display("FAIL bj_final_pc got %h want 0008", pc); end
    endtask

    task automatic test_illegal();
        int cyc;
        clear_rom();
        rom[0] = ei(4'h4, 2'd1, 2'd1, 8'h01);
        rom[1] = ei(4'h4, 2'd1, 2'd1, 8'h01);
        rom[2] = ei(4'h4, 2'd1, 2'd1, 8'h01);
        rom[3] = {16'h0000, 16'hC000};
        wait_cfg = 0;
        do_reset();
        run_to_halt(cyc);
        checks++; if (cyc != 14) begin errors++; $display("FAIL ill_cycles got %0d want 14", cyc); end
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %b want 1", illegal); end
        checks++; if (num_inst !== 32'd3) begin errors++; $display("FAIL ill_num_inst got %0d want 3", num_inst); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (mem_req !== 1'b0 || is_halted !== 1'b1) begin errors++; $display("FAIL ill_stays_halted got req=%b halt=%b want 0/1", mem_req, is_halted); end
        checks++; if (rd_cnt != 4 || pc !== 16'h0003) begin errors++; $display("FAIL ill_no_fetch got reads=%0d pc=%h want 4/0003", rd_cnt, pc); end
    endtask

    task automatic test_reset_mid_access();
        int cyc;
        bit seen;
        clear_rom();
        rom[8'h40] = 32'h12345678;
        rom[0] = ei(4'h4, 2'd0, 2'd1, 8'h07);
        rom[1] = er(2'd1, 2'd0, 2'd0, 6'd28);
        rom[2] = ei(4'h7, 2'd0, 2'd2, 8'h40);
        rom[3] = er(2'd0, 2'd0, 2'd0, 6'd29);
        wait_cfg = 3;
        do_reset();
        seen = 0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #1;
            if (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 16'h0040) begin
                seen = 1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_reach_lwd got timeout want mem wait at 0040"); end
        checks++; if (out_data !== 32'd7 || num_inst !== 32'd2) begin errors++; $display("FAIL mid_pre_state got out=%h n=%0d want 7/2", out_data, num_inst); end
        @(negedge clk);
        reset_n = 1'b0;
        clear_rom();
        rom[0] = er(2'd1, 2'd0, 2'd0, 6'd28);
        rom[1] = er(2'd2, 2'd0, 2'd0, 6'd28);
        rom[2] = er(2'd0, 2'd0, 2'd0, 6'd29);
        @(posedge clk);
        #1;
        checks++; if (pc !== 16'h0000 || num_inst !== 32'd0) begin errors++; $display("FAIL mid_reset_pc got pc=%h n=%0d want 0000/0", pc, num_inst); end
        checks++; if (out_data !== 32'd0 || out_valid !== 1'b0 || illegal !== 1'b0 || is_halted !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outs got out=%h ov=%b ill=%b halt=%b want 0", out_data, out_valid, illegal, is_halted);
        end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("FAIL mid_reset_fetch got req=%b addr=%h want 1/0000", mem_req, mem_addr); end
        @(negedge clk);
        wait_cfg = 0;
        reset_n = 1'b1;
        run_to_halt(cyc);
        checks++; if (cyc != 8) begin errors++; $display("FAIL mid_restart_cycles got %0d want 8", cyc); end
        checks++; if (wwd_cnt != 2 || wwd_log[0] !== 32'd0 || wwd_log[1] !== 32'd0) begin
            errors++; $display("FAIL mid_gprs_cleared got cnt=%0d r1=%h r2=%h want 2/0/0", wwd_cnt, wwd_log[0], wwd_log[1]);
        end
        checks++; if (num_inst !== 32'd2 || wr_cnt != 0) begin errors++; $display("FAIL mid_restart_count got n=%0d w=%0d want 2/0", num_inst, wr_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic(0, 17);
        test_basic(2, 27);
        test_load_store();
        test_branch_jump();
        test_illegal();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
